tensor_core_matrix_loader: RTL

//  Upstream feeder for the tensor-core register file. Accepts a serial stream of signed 8-bit elements

---
 rtl/tensor_core_pkg.sv | 18 +
 rtl/tensor_core_matrix_loader.sv | 81 ++++++++
 2 files changed

// File: rtl/tensor_core_pkg.sv
// Constants and types shared by the matrix loader, the register file and the tensor core.
package tensor_core_pkg;

  localparam int BUS_WIDTH        = 8;
  localparam int MATRIX_DIM       = 4;
  localparam int ELEMS_PER_MATRIX = MATRIX_DIM * MATRIX_DIM;

  typedef enum logic [1:0] {
    LOADER_IDLE,
    LOADER_LOAD,
    LOADER_COMMIT
  } loader_state_t;

  function automatic int num_matrices(input int nr);
    return (nr - 1) / ELEMS_PER_MATRIX + 1;
  endfunction

endpackage

// File: rtl/tensor_core_matrix_loader.sv
// Collects a serial stream of signed elements into a staging copy of the register-file
// layout and issues one bulk write once the full set is present and the core is idle.
module tensor_core_matrix_loader
  import tensor_core_pkg::*;
#(
  parameter int NUMBER_OF_REGISTERS = 32,
  parameter int DATA_WIDTH          = BUS_WIDTH
) (
  input  logic                                  clock_in,
  input  logic                                  reset_in,
  input  logic                                  start_in,
  input  logic                                  abort_in,
  input  logic signed [DATA_WIDTH-1:0]          data_in,
  input  logic                                  data_valid_in,
  output logic                                  data_ready_out,
  input  logic                                  core_busy_in,
  output logic                                  bulk_write_enable_out,
  output logic signed [num_matrices(NUMBER_OF_REGISTERS)-1:0][MATRIX_DIM-1:0][MATRIX_DIM-1:0][DATA_WIDTH-1:0]
                                                bulk_write_data_out,
  output logic                                  busy_out,
  output logic                                  done_out,
  output logic [$clog2(NUMBER_OF_REGISTERS):0]  element_count_out
);

  localparam int NUM_MATRICES = num_matrices(NUMBER_OF_REGISTERS);
  localparam int COUNT_W      = $clog2(NUMBER_OF_REGISTERS) + 1;

  loader_state_t      state;
  logic [COUNT_W-1:0] count;

  assign data_ready_out    = (state == LOADER_LOAD);
  assign busy_out          = (state != LOADER_IDLE);
  assign element_count_out = count;

  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      state                 <= LOADER_IDLE;
      count                 <= '0;
      bulk_write_data_out   <= '0;
      bulk_write_enable_out <= 1'b0;
      done_out              <= 1'b0;
    end else begin
      bulk_write_enable_out <= 1'b0;
      done_out              <= 1'b0;
      case (state)
        LOADER_IDLE: begin
          if (start_in) begin
            state               <= LOADER_LOAD;
            count               <= '0;
            bulk_write_data_out <= '0;
          end
        end
        LOADER_LOAD: begin
          if (abort_in) begin
            state <= LOADER_IDLE;
            count <= '0;
          end else if (data_valid_in) begin
            // Matrix-major, then row-major placement of element number 'count'.
            for (int m = 0; m < NUM_MATRICES; m++)
              for (int r = 0; r < MATRIX_DIM; r++)
                for (int c = 0; c < MATRIX_DIM; c++)
                  if (count == COUNT_W'(m * ELEMS_PER_MATRIX + r * MATRIX_DIM + c))
                    bulk_write_data_out[m][r][c] <= data_in;
            count <= count + 1'b1;
            if (count == COUNT_W'(NUMBER_OF_REGISTERS - 1))
              state <= LOADER_COMMIT;
          end
        end
        LOADER_COMMIT: begin
          if (!core_busy_in) begin
            bulk_write_enable_out <= 1'b1;
            done_out              <= 1'b1;
            state                 <= LOADER_IDLE;
          end
        end
        default: state <= LOADER_IDLE;
      endcase
    end
  end

endmodule
